// File: rtl/ibex_pkg.sv
// Shared types and defaults for the bf16 multiply arbiter and the FP ALU multiplier.
package ibex_pkg;

    localparam int unsigned FP_MUL_ARB_NUM_PORTS = 2;
    localparam int unsigned FP_MUL_ARB_TAG_W     = 4;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } fp_mul_arb_state_e;

    typedef enum logic [1:0] {
        FP_ALU_ADD = 2'd0,
        FP_ALU_SUB = 2'd1,
        FP_ALU_MUL = 2'd2,
        FP_ALU_DIV = 2'd3
    } fp_alu_op_e;

    // Width of a port index; a single-port arbiter still carries a 1-bit index.
    function automatic int unsigned arb_idx_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/Mult.sv
// Combinational bf16 multiplier: round-to-nearest-even, subnormals flushed to zero,
// NaN results canonicalised to 0x7FC0. Only FP_ALU_MUL produces a result.
module Mult
    import ibex_pkg::*;
(
    input  fp_alu_op_e  operator_i,
    input  logic [15:0] op_a_i,
    input  logic [15:0] op_b_i,
    output logic [15:0] result_o
);

    logic              sign;
    logic [7:0]        exp_a, exp_b;
    logic [6:0]        frac_a, frac_b;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [15:0]       prod;
    logic signed [9:0] exp_sum, exp_norm, exp_rnd;
    logic [6:0]        frac_norm, frac_rnd;
    logic              guard, sticky, round_up;
    logic [7:0]        frac_inc;

    assign sign   = op_a_i[15] ^ op_b_i[15];
    assign exp_a  = op_a_i[14:7];
    assign exp_b  = op_b_i[14:7];
    assign frac_a = op_a_i[6:0];
    assign frac_b = op_b_i[6:0];

    assign a_nan  = (exp_a == 8'hFF) && (frac_a != 7'd0);
    assign b_nan  = (exp_b == 8'hFF) && (frac_b != 7'd0);
    assign a_inf  = (exp_a == 8'hFF) && (frac_a == 7'd0);
    assign b_inf  = (exp_b == 8'hFF) && (frac_b == 7'd0);
    assign a_zero = (exp_a == 8'h00);
    assign b_zero = (exp_b == 8'h00);

    assign prod    = {8'h00, 1'b1, frac_a} * {8'h00, 1'b1, frac_b};
    assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

    always_comb begin
        // Product of two [1,2) significands lies in [1,4); bit 15 marks the [2,4) case.
        if (prod[15]) begin
            frac_norm = prod[14:8];
            guard     = prod[7];
            sticky    = |prod[6:0];
            exp_norm  = exp_sum + 10'sd1;
        end else begin
            frac_norm = prod[13:7];
            guard     = prod[6];
            sticky    = |prod[5:0];
            exp_norm  = exp_sum;
        end
        round_up = guard & (sticky | frac_norm[0]);
        frac_inc = {1'b0, frac_norm} + {7'd0, round_up};
        exp_rnd  = frac_inc[7] ? (exp_norm + 10'sd1) : exp_norm;
        frac_rnd = frac_inc[6:0];

        result_o = 16'h0000;
        if (operator_i == FP_ALU_MUL) begin
            if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                result_o = BF16_QNAN;
            end else if (a_inf || b_inf) begin
                result_o = {sign, 8'hFF, 7'd0};
            end else if (a_zero || b_zero) begin
                result_o = {sign, 15'd0};
            end else if (exp_rnd >= 10'sd255) begin
                result_o = {sign, 8'hFF, 7'd0};
            end else if (exp_rnd <= 10'sd0) begin
                result_o = {sign, 15'd0};
            end else begin
                result_o = {sign, exp_rnd[7:0], frac_rnd};
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that feeds one shared bf16 multiplier and returns tagged results.
//   state | meaning
//   IDLE  | no operation held; grant a pending request into the operand register
//   EXEC  | multiplier driven from operand register; result registered at the edge
//   RESP  | result presented until consumed; may grant the next request on consume
module fp_mul_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned NUM_PORTS = FP_MUL_ARB_NUM_PORTS,
    parameter int unsigned TAG_W     = FP_MUL_ARB_TAG_W
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic [NUM_PORTS-1:0]                req_valid_i,
    output logic [NUM_PORTS-1:0]                req_ready_o,
    input  logic [16*NUM_PORTS-1:0]             req_a_i,
    input  logic [16*NUM_PORTS-1:0]             req_b_i,
    input  logic [TAG_W*NUM_PORTS-1:0]          req_tag_i,
    output logic                                rsp_valid_o,
    input  logic                                rsp_ready_i,
    output logic [15:0]                         rsp_data_o,
    output logic [arb_idx_w(NUM_PORTS)-1:0]     rsp_port_o,
    output logic [TAG_W-1:0]                    rsp_tag_o,
    output logic                                rsp_nan_o,
    output logic                                rsp_inf_o
);

    localparam int unsigned PW = arb_idx_w(NUM_PORTS);

    fp_mul_arb_state_e state_q, state_d;
    logic [PW-1:0]     prio_q, prio_d;
    logic [15:0]       op_a_q, op_a_d, op_b_q, op_b_d;
    logic [PW-1:0]     op_port_q, op_port_d;
    logic [TAG_W-1:0]  op_tag_q, op_tag_d;
    logic [15:0]       res_data_q, res_data_d;
    logic [PW-1:0]     res_port_q, res_port_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;

    logic              grant_found, grant_en;
    logic [PW-1:0]     grant_idx;
    logic [15:0]       sel_a, sel_b;
    logic [TAG_W-1:0]  sel_tag;
    logic [15:0]       mul_res;

    Mult u_mult (
        .operator_i (FP_ALU_MUL),
        .op_a_i     (op_a_q),
        .op_b_i     (op_b_q),
        .result_o   (mul_res)
    );

    // First pass searches ports at or above the priority pointer, second pass wraps around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        sel_a       = '0;
        sel_b       = '0;
        sel_tag     = '0;
        for (int unsigned pass = 0; pass < 2; pass++) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (!grant_found && req_valid_i[PW'(p)] &&
                    ((p >= 32'(prio_q)) == (pass == 0))) begin
                    grant_found = 1'b1;
                    grant_idx   = PW'(p);
                    sel_a       = req_a_i[16*p +: 16];
                    sel_b       = req_b_i[16*p +: 16];
                    sel_tag     = req_tag_i[TAG_W*p +: TAG_W];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_port_d  = op_port_q;
        op_tag_d   = op_tag_q;
        res_data_d = res_data_q;
        res_port_d = res_port_q;
        res_tag_d  = res_tag_q;
        grant_en   = 1'b0;
        req_ready_o = '0;

        unique case (state_q)
            IDLE: grant_en = grant_found && !flush_i;
            EXEC: begin
                if (!flush_i) begin
                    res_data_d = mul_res;
                    res_port_d = op_port_q;
                    res_tag_d  = op_tag_q;
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d  = IDLE;
                    grant_en = grant_found && !flush_i;
                end
            end
            default: state_d = IDLE;
        endcase

        if (grant_en) begin
            state_d   = EXEC;
            op_a_d    = sel_a;
            op_b_d    = sel_b;
            op_port_d = grant_idx;
            op_tag_d  = sel_tag;
            prio_d    = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : (grant_idx + PW'(1));
            // Ready is a combinational echo of the grant, so it must not leak out during reset.
            if (!rst_i) begin
                req_ready_o[grant_idx] = 1'b1;
            end
        end

        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            prio_q     <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_port_q  <= '0;
            op_tag_q   <= '0;
            res_data_q <= '0;
            res_port_q <= '0;
            res_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_port_q  <= op_port_d;
            op_tag_q   <= op_tag_d;
            res_data_q <= res_data_d;
            res_port_q <= res_port_d;
            res_tag_q  <= res_tag_d;
        end
    end

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_data_o  = res_data_q;
    assign rsp_port_o  = res_port_q;
    assign rsp_tag_o   = res_tag_q;
    assign rsp_nan_o   = (res_data_q[14:7] == 8'hFF) && (res_data_q[6:0] != 7'd0);
    assign rsp_inf_o   = (res_data_q[14:7] == 8'hFF) && (res_data_q[6:0] == 7'd0);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter: stimulus queues hand-computed expectations at
// each request handshake, and a negedge monitor checks every consumed response.
module tb_fp_mul_arbiter;
    localparam int NP = 2;
    localparam int TW = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic [NP-1:0]     req_valid_i;
    logic [NP-1:0]     req_ready_o;
    logic [16*NP-1:0]  req_a_i, req_b_i;
    logic [TW*NP-1:0]  req_tag_i;
    logic              rsp_valid_o, rsp_ready_i;
    logic [15:0]       rsp_data_o;
    logic [0:0]        rsp_port_o;
    logic [TW-1:0]     rsp_tag_o;
    logic              rsp_nan_o, rsp_inf_o;

    typedef struct packed {
        logic [15:0]   data;
        logic          port;
        logic [TW-1:0] tag;
        logic          nan;
        logic          inf;
    } rsp_t;

    rsp_t sb_q[$];
    rsp_t pend[NP];
    int   rsp_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    fp_mul_arbiter #(.NUM_PORTS(NP), .TAG_W(TW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_tag_i   (req_tag_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_port_o  (rsp_port_o),
        .rsp_tag_o   (rsp_tag_o),
        .rsp_nan_o   (rsp_nan_o),
        .rsp_inf_o   (rsp_inf_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("ready_onehot", 32'($onehot0(req_ready_o)), 32'd1);
            for (int p = 0; p < NP; p++)
                if (req_valid_i[p] && req_ready_o[p]) sb_q.push_back(pend[p]);
            if (rsp_valid_o && rsp_ready_i) begin
                rsp_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got data 0x%0h tag 0x%0h, expected no response",
                             rsp_data_o, rsp_tag_o);
                end else begin
                    rsp_t e;
                    e = sb_q.pop_front();
                    check("rsp_data", 32'(rsp_data_o), 32'(e.data));
                    check("rsp_port", 32'(rsp_port_o), 32'(e.port));
                    check("rsp_tag",  32'(rsp_tag_o),  32'(e.tag));
                    check("rsp_nan",  32'(rsp_nan_o),  32'(e.nan));
                    check("rsp_inf",  32'(rsp_inf_o),  32'(e.inf));
                end
            end
        end
    end

    task automatic present(input int p, input logic [15:0] a, input logic [15:0] b,
                           input logic [TW-1:0] tag, input logic [15:0] d,
                           input logic nan, input logic inf);
        pend[p] = '{data: d, port: 1'(p), tag: tag, nan: nan, inf: inf};
        req_a_i[16*p +: 16]   = a;
        req_b_i[16*p +: 16]   = b;
        req_tag_i[TW*p +: TW] = tag;
        req_valid_i[p]        = 1'b1;
    endtask

    task automatic await_accept(input int p);
        bit ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk_i);
            if (req_ready_o[p]) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: port %0d ready=0 after 30 cycles, expected 1", p);
        end
        @(posedge clk_i);
        #1 req_valid_i[p] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb_q.size());
        end
        @(posedge clk_i);
        #1;
    endtask

    logic [15:0] va [10] = '{16'h7FC1, 16'h7F80, 16'h7F80, 16'hFF80, 16'hBF80,
                             16'h7F00, 16'h3F81, 16'h3FC1, 16'h3F81, 16'h3F83};
    logic [15:0] vb [10] = '{16'h3F80, 16'h0000, 16'h4000, 16'h4000, 16'h0000,
                             16'h4000, 16'h3F81, 16'h3FC1, 16'h3FC0, 16'h3FC0};
    logic [15:0] ve [10] = '{16'h7FC0, 16'h7FC0, 16'h7F80, 16'hFF80, 16'h8000,
                             16'h7F80, 16'h3F82, 16'h4012, 16'h3FC2, 16'h3FC4};
    logic        vn [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        vi [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        req_tag_i   = '0;
        rsp_ready_i = 1'b1;

        // Both ports pending while reset is held: nothing may be granted or presented.
        present(0, 16'h4000, 16'h4040, 4'h1, 16'h40C0, 1'b0, 1'b0);
        present(1, 16'h3F80, 16'hC000, 4'h2, 16'hC000, 1'b0, 1'b0);
        repeat (2) @(negedge clk_i);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_data",  32'(rsp_data_o),  32'd0);
        check("rst_rsp_port",  32'(rsp_port_o),  32'd0);
        check("rst_rsp_tag",   32'(rsp_tag_o),   32'd0);
        check("rst_rsp_nan",   32'(rsp_nan_o),   32'd0);
        check("rst_rsp_inf",   32'(rsp_inf_o),   32'd0);
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Port 0 wins first after reset, port 1 follows two cycles later.
        await_accept(0);
        await_accept(1);
        drain();
        check("rr_rsp_count", 32'(rsp_cyc.size()), 32'd2);
        if (rsp_cyc.size() == 2) check("rr_rsp_spacing", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd2);

        // Latency: granted cycle, then EXEC, then RESP.
        present(0, 16'h3F80, 16'h3F80, 4'h3, 16'h3F80, 1'b0, 1'b0);
        await_accept(0);
        @(negedge clk_i);
        check("lat_exec_valid", 32'(rsp_valid_o), 32'd0);
        @(negedge clk_i);
        check("lat_resp_valid", 32'(rsp_valid_o), 32'd1);
        drain();

        // Special values, overflow and rounding, alternating ports back to back.
        for (int i = 0; i < 10; i++) begin
            present(i % 2, va[i], vb[i], 4'(i + 4), ve[i], vn[i], vi[i]);
            await_accept(i % 2);
        end
        drain();

        // Consumer stall: response held, port 1 waits, then is granted on release.
        rsp_ready_i = 1'b0;
        present(0, 16'h4000, 16'h4000, 4'h1, 16'h4080, 1'b0, 1'b0);
        await_accept(0);
        present(1, 16'h3F80, 16'h4040, 4'h9, 16'h4040, 1'b0, 1'b0);
        n = 0;
        while (!rsp_valid_o && n < 10) begin
            @(negedge clk_i);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(rsp_valid_o), 32'd1);
            check("stall_data",  32'(rsp_data_o),  32'h4080);
            check("stall_port",  32'(rsp_port_o),  32'd0);
            check("stall_tag",   32'(rsp_tag_o),   32'h1);
            check("stall_ready", 32'(req_ready_o), 32'd0);
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("release_grant", 32'(req_ready_o), 32'b10);
        @(posedge clk_i);
        #1 req_valid_i[1] = 1'b0;
        drain();

        // Flush during EXEC discards the operation.
        present(0, 16'h4040, 16'h4040, 4'h5, 16'h4110, 1'b0, 1'b0);
        await_accept(0);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        sb_q.delete(sb_q.size() - 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("flush_no_rsp", 32'(rsp_valid_o), 32'd0);
        end
        present(1, 16'h3F80, 16'h4000, 4'hA, 16'h4000, 1'b0, 1'b0);
        await_accept(1);
        drain();

        // Flush beats a grant in IDLE.
        present(1, 16'hC040, 16'h4000, 4'hC, 16'hC0C0, 1'b0, 1'b0);
        flush_i = 1'b1;
        @(negedge clk_i);
        check("flush_blocks_grant", 32'(req_ready_o), 32'd0);
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        await_accept(1);
        drain();

        // Asynchronous reset in EXEC: outputs clear at once, no response afterwards.
        present(0, 16'h4000, 16'h4000, 4'h7, 16'h4080, 1'b0, 1'b0);
        await_accept(0);
        present(1, 16'h3F80, 16'h3F80, 4'h8, 16'h3F80, 1'b0, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("arst_rsp_data",  32'(rsp_data_o),  32'd0);
        check("arst_rsp_port",  32'(rsp_port_o),  32'd0);
        check("arst_rsp_tag",   32'(rsp_tag_o),   32'd0);
        check("arst_rsp_nan",   32'(rsp_nan_o),   32'd0);
        check("arst_rsp_inf",   32'(rsp_inf_o),   32'd0);
        check("arst_req_ready", 32'(req_ready_o), 32'd0);
        sb_q.delete();
        req_valid_i = '0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            check("arst_no_rsp", 32'(rsp_valid_o), 32'd0);
        end

        // Normal operation resumes after reset.
        present(1, 16'h3F80, 16'h3F80, 4'h8, 16'h3F80, 1'b0, 1'b0);
        await_accept(1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
